// File: rtl/sram_dp_pipelined.sv
// Dual-port SRAM: port A read/write, port B read-only, pipelined reads with byte masks,
// same-cycle A-write/B-read forwarding, out-of-range error responses and optional zero-fill.
module sram_dp_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 1,
  parameter int INIT_ZERO    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       a_req_valid,
  output logic                       a_req_ready,
  input  logic                       a_we,
  input  logic [DATA_WIDTH/8-1:0]    a_wmask,
  input  logic [ADDR_WIDTH-1:0]      a_addr,
  input  logic [DATA_WIDTH-1:0]      a_wdata,
  output logic                       a_rsp_valid,
  output logic [DATA_WIDTH-1:0]      a_rdata,
  output logic                       a_err,
  input  logic                       b_req_valid,
  output logic                       b_req_ready,
  input  logic [ADDR_WIDTH-1:0]      b_addr,
  output logic                       b_rsp_valid,
  output logic [DATA_WIDTH-1:0]      b_rdata,
  output logic                       b_err,
  output logic                       init_done
);

  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int MEM_AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_RST,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [MEM_AW-1:0]       ptr_q, ptr_d;
  logic                    ready_q, ready_d;
  logic                    init_done_q, init_done_d;

  logic [READ_LATENCY-1:0] a_vld_q, a_vld_d;
  logic [READ_LATENCY-1:0] a_err_q, a_err_d;
  logic [DATA_WIDTH-1:0]   a_dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   a_dat_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] b_vld_q, b_vld_d;
  logic [READ_LATENCY-1:0] b_err_q, b_err_d;
  logic [DATA_WIDTH-1:0]   b_dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   b_dat_d [READ_LATENCY];

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    a_acc, b_acc;
  logic                    a_in_range, b_in_range;
  logic [MEM_AW-1:0]       a_idx, b_idx;
  logic                    a_wr;
  logic [DATA_WIDTH-1:0]   a_word, b_word;

  logic                    wr_en;
  logic [MEM_AW-1:0]       wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_WMASKS-1:0]   wr_mask;

  assign a_acc      = a_req_valid & ready_q;
  assign b_acc      = b_req_valid & ready_q;
  assign a_in_range = {1'b0, a_addr} < ADDR_LIMIT;
  assign b_in_range = {1'b0, b_addr} < ADDR_LIMIT;
  assign a_idx      = a_addr[MEM_AW-1:0];
  assign b_idx      = b_addr[MEM_AW-1:0];
  assign a_wr       = a_acc & a_we & a_in_range;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_RST: begin
        ptr_d   = '0;
        state_d = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        if (ptr_q == MEM_AW'(RAM_DEPTH - 1)) state_d = ST_RUN;
        else                                  ptr_d   = ptr_q + MEM_AW'(1);
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
    ready_d     = (state_d == ST_RUN);
    init_done_d = (state_d == ST_RUN);
  end

  // The zero-fill sweep owns the write port until RUN, when port A takes over.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    wr_mask = '0;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_q;
      wr_mask = '1;
    end else if (a_wr) begin
      wr_en   = 1'b1;
      wr_idx  = a_idx;
      wr_data = a_wdata;
      wr_mask = a_wmask;
    end
  end

  always_comb begin
    a_word = mem[a_idx];
    b_word = mem[b_idx];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (RDW_MODE == 1 && a_wr && a_addr == b_addr && a_wmask[i])
        b_word[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  // Stage 0 captures the accept-edge result; later stages just delay it, so idle slots carry zeros.
  always_comb begin
    a_vld_d    = '0;
    a_err_d    = '0;
    b_vld_d    = '0;
    b_err_d    = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      a_dat_d[i] = '0;
      b_dat_d[i] = '0;
    end
    a_vld_d[0] = a_acc;
    a_err_d[0] = a_acc & ~a_in_range;
    a_dat_d[0] = (a_acc & ~a_we & a_in_range) ? a_word : '0;
    b_vld_d[0] = b_acc;
    b_err_d[0] = b_acc & ~b_in_range;
    b_dat_d[0] = (b_acc & b_in_range) ? b_word : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      a_vld_d[i] = a_vld_q[i-1];
      a_err_d[i] = a_err_q[i-1];
      a_dat_d[i] = a_dat_q[i-1];
      b_vld_d[i] = b_vld_q[i-1];
      b_err_d[i] = b_err_q[i-1];
      b_dat_d[i] = b_dat_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST;
      ptr_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      a_vld_q     <= '0;
      a_err_q     <= '0;
      b_vld_q     <= '0;
      b_err_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        a_dat_q[i] <= '0;
        b_dat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      a_vld_q     <= a_vld_d;
      a_err_q     <= a_err_d;
      b_vld_q     <= b_vld_d;
      b_err_q     <= b_err_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        a_dat_q[i] <= a_dat_d[i];
        b_dat_q[i] <= b_dat_d[i];
      end
    end
  end

  // Array contents survive reset; only the byte lanes selected by the mask change.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign a_req_ready = ready_q;
  assign b_req_ready = ready_q;
  assign init_done   = init_done_q;
  assign a_rsp_valid = a_vld_q[READ_LATENCY-1];
  assign a_err       = a_err_q[READ_LATENCY-1];
  assign a_rdata     = a_dat_q[READ_LATENCY-1];
  assign b_rsp_valid = b_vld_q[READ_LATENCY-1];
  assign b_err       = b_err_q[READ_LATENCY-1];
  assign b_rdata     = b_dat_q[READ_LATENCY-1];

endmodule
